// File: rtl/acc_cpu.sv
// acc_cpu: parametrised 3-cycle accumulator CPU with loadable imem.
// Define ACC_CPU_MUL_EN to make opcode E a multiply; otherwise E is a NOP.
module acc_cpu #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wakeup,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [DW+3:0] prog_data,
   output logic [DW-1:0] acc,
   output logic [AW-1:0] pc,
   output logic          zf,
   output logic          cf,
   output logic          sleeping,
   output logic          halted
);

   localparam int IW = DW + 4;
   localparam int NW = 1 << AW;

   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_XNOR = 4'h7;
   localparam logic [3:0] OP_SLP  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_JZ   = 4'hC;
   localparam logic [3:0] OP_JC   = 4'hD;
`ifdef ACC_CPU_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'hE;
`endif
   localparam logic [3:0] OP_HLT  = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_SLEEP,
      S_HALT
   } state_t;

   state_t        state;
   logic [IW-1:0] imem [NW];
   logic [DW-1:0] dmem [NW];
   logic [IW-1:0] ir;
   logic [DW-1:0] mdr;

   logic [3:0]    opc;
   logic [DW-1:0] opnd;
   logic [AW-1:0] addr;
   logic [DW:0]   add_res;
   logic [DW:0]   sub_res;

   logic [DW-1:0] res;
   logic          acc_we;
   logic          cf_we;
   logic          cf_nxt;
   logic          jmp;

   assign opc     = ir[3:0];
   assign opnd    = ir[IW-1:4];
   assign addr    = opnd[AW-1:0];
   assign add_res = {1'b0, acc} + {1'b0, mdr};
   // The top bit of a widened subtract is the unsigned borrow.
   assign sub_res = {1'b0, acc} - {1'b0, mdr};

`ifdef ACC_CPU_MUL_EN
   logic [2*DW-1:0] mul_res;
   assign mul_res = {{DW{1'b0}}, acc} * {{DW{1'b0}}, mdr};
`endif

   always_comb begin
      res    = acc;
      acc_we = 1'b0;
      cf_we  = 1'b0;
      cf_nxt = cf;
      jmp    = 1'b0;
      case (opc)
         OP_LDI:  begin res = opnd; acc_we = 1'b1; end
         OP_ADD:  begin
            res    = add_res[DW-1:0];
            acc_we = 1'b1;
            cf_we  = 1'b1;
            cf_nxt = add_res[DW];
         end
         OP_SUB:  begin
            res    = sub_res[DW-1:0];
            acc_we = 1'b1;
            cf_we  = 1'b1;
            cf_nxt = sub_res[DW];
         end
         OP_AND:  begin res = acc & mdr; acc_we = 1'b1; end
         OP_OR:   begin res = acc | mdr; acc_we = 1'b1; end
         OP_XOR:  begin res = acc ^ mdr; acc_we = 1'b1; end
         OP_XNOR: begin res = ~(acc ^ mdr); acc_we = 1'b1; end
         OP_LD:   begin res = mdr; acc_we = 1'b1; end
         OP_JMP:  jmp = 1'b1;
         OP_JZ:   jmp = zf;
         OP_JC:   jmp = cf;
`ifdef ACC_CPU_MUL_EN
         OP_MUL:  begin
            res    = mul_res[DW-1:0];
            acc_we = 1'b1;
            cf_we  = 1'b1;
            cf_nxt = |mul_res[2*DW-1:DW];
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         pc       <= '0;
         acc      <= '0;
         zf       <= 1'b0;
         cf       <= 1'b0;
         ir       <= '0;
         mdr      <= '0;
         sleeping <= 1'b0;
         halted   <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               ir    <= imem[pc];
               pc    <= pc + AW'(1);
               state <= S_DECODE;
            end
            S_DECODE: begin
               mdr   <= dmem[addr];
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (acc_we) begin
                  acc <= res;
                  zf  <= (res == '0);
               end
               if (cf_we) cf <= cf_nxt;
               if (jmp) pc <= addr;
               if (opc == OP_SLP) begin
                  state    <= S_SLEEP;
                  sleeping <= 1'b1;
               end else if (opc == OP_HLT) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_SLEEP: begin
               if (wakeup) begin
                  state    <= S_FETCH;
                  sleeping <= 1'b0;
               end
            end
            S_HALT:  ;
            default: state <= S_FETCH;
         endcase
      end
   end

   // Program loading stays live through reset so a boot loader can hold it.
   always_ff @(posedge clk) begin
      if (prog_we) imem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (!reset && state == S_EXEC && opc == OP_ST)
         dmem[addr] <= acc;
   end

endmodule

// File: tb/tb_acc_cpu.sv
// Bench for acc_cpu: directed table, corner sequences and
// randomized programs against an instruction-level model.
module tb_acc_cpu;

   logic        clk = 1'b0;
   logic        reset;
   logic        wakeup;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [11:0] prog_data;
   logic [7:0]  acc;
   logic [3:0]  pc;
   logic        zf, cf, sleeping, halted;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   acc_cpu #(.DW(8), .AW(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .wakeup    (wakeup),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .acc       (acc),
      .pc        (pc),
      .zf        (zf),
      .cf        (cf),
      .sleeping  (sleeping),
      .halted    (halted)
   );

   typedef struct {
      logic [3:0] op;
      logic [7:0] av;
      logic [7:0] mv;
      logic [7:0] ea;
      logic       ez;
      logic       ec;
   } vec_t;

   vec_t        tab[$];
   vec_t        v;
   logic [11:0] prog [16];

   logic [7:0] m_acc;
   logic [3:0] m_pc;
   logic       m_zf, m_cf, m_slp, m_hlt;
   logic [7:0] m_dmem [16];

   function automatic logic [11:0] mk(input logic [3:0] op,
                                      input logic [7:0] imm);
      return {imm, op};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = mk(4'hF, 8'h00);
   endtask

   // Hold reset, load the whole program, release before edge 1.
   task automatic start();
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         prog_we   = 1'b1;
         prog_addr = 4'(i);
         prog_data = prog[i];
      end
      @(negedge clk);
      prog_we = 1'b0;
      reset   = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_halt(input string nm, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (!halted) begin
         bad++;
         $display("FAIL %s: halt timeout got 0 want 1", nm);
      end
   endtask

   task automatic m_put(input int r);
      m_acc = 8'(r);
      m_zf  = (m_acc == 8'h00);
   endtask

   task automatic iss_step();
      logic [11:0] w;
      logic [3:0]  op, a;
      logic [7:0]  imm, md;
      int          r;
      w    = prog[m_pc];
      op   = w[3:0];
      imm  = w[11:4];
      a    = imm[3:0];
      md   = m_dmem[a];
      m_pc = m_pc + 4'd1;
      case (op)
         4'h1: m_put(int'(imm));
         4'h2: begin
            r    = int'(m_acc) + int'(md);
            m_cf = (r > 255);
            m_put(r);
         end
         4'h3: begin
            m_cf = (m_acc < md);
            m_put(int'(m_acc) - int'(md));
         end
         4'h4: m_put(int'(m_acc & md));
         4'h5: m_put(int'(m_acc | md));
         4'h6: m_put(int'(m_acc ^ md));
         4'h7: m_put(int'(~(m_acc ^ md)));
         4'h8: m_slp = 1'b1;
         4'h9: m_put(int'(md));
         4'hA: m_dmem[a] = m_acc;
         4'hB: m_pc = a;
         4'hC: if (m_zf) m_pc = a;
         4'hD: if (m_cf) m_pc = a;
`ifdef ACC_CPU_MUL_EN
         4'hE: begin
            r    = int'(m_acc) * int'(md);
            m_cf = ((r / 256) != 0);
            m_put(r);
         end
`endif
         4'hF: m_hlt = 1'b1;
         default: ;
      endcase
   endtask

   initial begin
      int k;
      logic [7:0] dv;
      reset     = 1'b1;
      wakeup    = 1'b0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      #2;
      chk("rst_acc", acc, 0);
      chk("rst_pc", pc, 0);
      chk("rst_zf", zf, 0);
      chk("rst_cf", cf, 0);
      chk("rst_slp", sleeping, 0);
      chk("rst_hlt", halted, 0);

      // Directed ALU table: LDI mv; ST 0; LDI av; op 0; HLT
      tab.push_back('{4'h2, 8'h03, 8'h05, 8'h08, 1'b0, 1'b0});
      tab.push_back('{4'h2, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1});
      tab.push_back('{4'h3, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1});
      tab.push_back('{4'h3, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0});
      tab.push_back('{4'h3, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0});
      tab.push_back('{4'h4, 8'h0F, 8'hC3, 8'h03, 1'b0, 1'b0});
      tab.push_back('{4'h5, 8'h0F, 8'hC3, 8'hCF, 1'b0, 1'b0});
      tab.push_back('{4'h6, 8'h0F, 8'hC3, 8'hCC, 1'b0, 1'b0});
      tab.push_back('{4'h7, 8'h0F, 8'hC3, 8'h33, 1'b0, 1'b0});
      tab.push_back('{4'h9, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0});
      tab.push_back('{4'h0, 8'h42, 8'h13, 8'h42, 1'b0, 1'b0});
      tab.push_back('{4'hD, 8'h07, 8'h00, 8'h07, 1'b0, 1'b0});
`ifdef ACC_CPU_MUL_EN
      tab.push_back('{4'hE, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1});
      tab.push_back('{4'hE, 8'h03, 8'h05, 8'h0F, 1'b0, 1'b0});
`else
      tab.push_back('{4'hE, 8'h10, 8'h10, 8'h10, 1'b0, 1'b0});
      tab.push_back('{4'hE, 8'h03, 8'h05, 8'h03, 1'b0, 1'b0});
`endif
      for (int i = 0; i < tab.size(); i++) begin
         v = tab[i];
         clear_prog();
         prog[0] = mk(4'h1, v.mv);
         prog[1] = mk(4'hA, 8'h00);
         prog[2] = mk(4'h1, v.av);
         prog[3] = mk(v.op, 8'h00);
         start();
         step(14);
         chk($sformatf("tab%0d_hlt14", i), halted, 0);
         step(1);
         chk($sformatf("tab%0d_acc", i), acc, v.ea);
         chk($sformatf("tab%0d_zf", i), zf, v.ez);
         chk($sformatf("tab%0d_cf", i), cf, v.ec);
         chk($sformatf("tab%0d_hlt15", i), halted, 1);
         step(4);
         chk($sformatf("tab%0d_pc", i), pc, 5);
      end

      // Branches: JZ taken, then not taken
      for (int t = 0; t < 2; t++) begin
         clear_prog();
         prog[0] = mk(4'h1, 8'(t));
         prog[1] = mk(4'hC, 8'h05);
         prog[2] = mk(4'h1, 8'hAA);
         prog[4] = mk(4'h0, 8'h00);
         prog[5] = mk(4'h1, 8'h55);
         start();
         wait_halt("jz", 60);
         chk($sformatf("jz%0d_acc", t), acc, (t == 0) ? 8'h55 : 8'hAA);
      end

      // Sleep: early pulse ignored, one-cycle wakeup resumes
      clear_prog();
      prog[0] = mk(4'h1, 8'h11);
      prog[1] = mk(4'h8, 8'h00);
      prog[2] = mk(4'h1, 8'h22);
      start();
      step(3);
      @(negedge clk);
      wakeup = 1'b1;
      @(negedge clk);
      wakeup = 1'b0;
      step(1);
      chk("slp_e5", sleeping, 0);
      step(1);
      chk("slp_e6", sleeping, 1);
      step(20);
      chk("slp_hold", sleeping, 1);
      chk("slp_acc", acc, 8'h11);
      chk("slp_pc", pc, 2);
      @(negedge clk);
      wakeup = 1'b1;
      @(negedge clk);
      wakeup = 1'b0;
      step(6);
      chk("wake_acc", acc, 8'h22);
      chk("wake_hlt", halted, 1);
      chk("wake_slp", sleeping, 0);

      start();
      step(6);
      chk("slp2", sleeping, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rs_acc", acc, 0);
      chk("rs_pc", pc, 0);
      chk("rs_zf", zf, 0);
      chk("rs_slp", sleeping, 0);
      chk("rs_hlt", halted, 0);

      // Write to the word being fetched: old word wins
      clear_prog();
      prog[0] = mk(4'h1, 8'h11);
      start();
      prog_we   = 1'b1;
      prog_addr = 4'h0;
      prog_data = mk(4'h1, 8'h77);
      @(negedge clk);
      prog_we = 1'b0;
      step(2);
      chk("wrf_old", acc, 8'h11);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      step(3);
      chk("wrf_new", acc, 8'h77);

      // pc wrap over 16 NOPs
      for (int i = 0; i < 16; i++) prog[i] = mk(4'h0, 8'h00);
      start();
      step(45);
      chk("wrap_pc15", pc, 15);
      step(1);
      chk("wrap_pc0", pc, 0);
      step(3);
      chk("wrap_pc1", pc, 1);
      chk("wrap_hlt", halted, 0);

      // Fill dmem with known values for the model
      for (int a = 0; a < 16; a++) begin
         dv = (a == 9) ? 8'h21 : 8'($urandom);
         clear_prog();
         prog[0] = mk(4'h1, dv);
         prog[1] = mk(4'hA, 8'(a));
         start();
         step(9);
         m_dmem[a] = dv;
      end
      chk("init_hlt", halted, 1);

      // Reset between ST decode and execute must not write
      clear_prog();
      prog[0] = mk(4'h1, 8'h99);
      prog[1] = mk(4'hA, 8'h09);
      start();
      step(5);
      @(negedge clk);
      reset = 1'b1;
      step(2);
      chk("rst_st_acc", acc, 0);
      clear_prog();
      prog[0] = mk(4'h9, 8'h09);
      start();
      step(6);
      chk("rst_st_mem", acc, m_dmem[9]);

      // Random programs against the instruction-level model
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 16; i++) prog[i] = 12'($urandom);
         k     = $urandom_range(1, 30);
         m_acc = '0;
         m_pc  = '0;
         m_zf  = 1'b0;
         m_cf  = 1'b0;
         m_slp = 1'b0;
         m_hlt = 1'b0;
         for (int s = 0; s < k; s++)
            if (!m_slp && !m_hlt) iss_step();
         start();
         step(3 * k);
         chk($sformatf("rnd%0d_acc", t), acc, m_acc);
         chk($sformatf("rnd%0d_pc", t), pc, m_pc);
         chk($sformatf("rnd%0d_zf", t), zf, m_zf);
         chk($sformatf("rnd%0d_cf", t), cf, m_cf);
         chk($sformatf("rnd%0d_slp", t), sleeping, m_slp);
         chk($sformatf("rnd%0d_hlt", t), halted, m_hlt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/acc_cpu.md
# acc_cpu

Parametrised accumulator CPU, the next generation of the team's 4-bit FSM core. It adds configurable data and address width, a loadable instruction memory, a memory-addressed ALU, load/store, conditional jumps, Z/C flags, and distinct sleep and halt states. It is a standalone, self-contained core: the bench or a boot controller loads the program, and `acc` plus the status pins are the observable outputs.

## Interface
- `DW`, default 8: data/accumulator width; the operand field is also `DW` bits wide; must satisfy DW ≥ AW.
- `AW`, default 4: address width; imem and dmem each hold 2^AW words.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `wakeup` input 1: level, sampled only in SLEEP.
- `prog_we` input 1: imem write strobe.
- `prog_addr` input AW: imem write address.
- `prog_data` input DW+4: instruction word, {operand[DW-1:0], opcode[3:0]}.
- `acc` output DW: accumulator.
- `pc` output AW: program counter.
- `zf` output 1: zero flag.
- `cf` output 1: carry/borrow flag.
- `sleeping` output 1: high while in SLEEP.
- `halted` output 1: high while in HALT.

## Operation
- Reset values: acc=0, pc=0, zf=0, cf=0, sleeping=0, halted=0; state=FETCH. imem and dmem are not reset.
- States: FETCH → DECODE → EXECUTE → FETCH; EXECUTE may go to SLEEP or HALT instead.
- SLEEP → FETCH on `wakeup`=1. HALT is left only by reset.
- FETCH: IR ← imem[pc]; pc ← pc+1, wrapping modulo 2^AW.
- DECODE: MDR ← dmem[a], where a = operand[AW-1:0].
- EXECUTE, opcode table (imm = operand):
  - 0 NOP.
  - 1 LDI: acc=imm.
  - 2 ADD: acc=acc+MDR; cf=carry out.
  - 3 SUB: acc=acc−MDR; cf=1 when acc<MDR (unsigned).
  - 4 AND: acc=acc&MDR.
  - 5 OR: acc=acc|MDR.
  - 6 XOR: acc=acc^MDR.
  - 7 XNOR: acc=~(acc^MDR).
  - 8 SLP: enter SLEEP.
  - 9 LD: acc=MDR.
  - A ST: dmem[a]=acc.
  - B JMP: pc=a.
  - C JZ: pc=a if zf.
  - D JC: pc=a if cf.
  - E: see Configuration.
  - F HLT: enter HALT.
- Flags:
  - zf updates on every acc write: (result==0).
  - cf updates only on ADD/SUB (and on MUL when enabled).
  - Arithmetic results are truncated to DW bits.
- A jump target overrides the FETCH increment.
- A not-taken JZ/JC behaves as NOP.
- imem writes via `prog_we` are accepted in every state, including during reset.

## Timing
- Every instruction takes exactly 3 cycles.
- acc, flags and dmem update on the EXECUTE edge.
- `sleeping`/`halted` assert the cycle after the SLP/HLT EXECUTE edge.
- Wakeup:
  - `wakeup` is sampled only in SLEEP; a pulse arriving before SLEEP is entered is ignored.
  - One sampled-high cycle is sufficient; FETCH begins on the next cycle.
- ST followed by LD of the same address returns the stored value; no hazard, because MDR is read in the later DECODE.
- A `prog_we` to the address being fetched in the same cycle: the fetch returns the old word.
- pc wraps from 2^AW−1 to 0 with no fault.
- Reset asserted mid-instruction aborts it. No partial dmem write is permitted after reset is asserted.

## Configuration
- `ACC_CPU_MUL_EN` defined: opcode E = MUL.
  - acc = low DW bits of acc×MDR.
  - cf=1 when the high DW bits are nonzero.
  - zf updates.
  - Still 3 cycles.
- `ACC_CPU_MUL_EN` undefined: opcode E executes as NOP; acc and flags are unchanged.

## Test plan
All scenarios use DW=8, AW=4.
- LDI 05; ST 0; LDI 03; ADD 0; HLT → acc=08, zf=0, cf=0, halted=1 at cycle 15; pc frozen.
- LDI FF; ST 1; LDI 01; ADD 1 → acc=00, zf=1, cf=1. Then LDI 01; ST 2; LDI 00; SUB 2 → acc=FF, cf=1, zf=0.
- Logic ops: LDI C3; ST 0; LDI 0F; then AND 0, OR 0, XOR 0, XNOR 0, each preceded by LDI 0F → acc=03, CF, CC, 33 in turn.
- Branches: LDI 00; JZ 5; LDI AA; HLT; NOP; LDI 55; HLT → acc=55. Repeat with LDI 01 first → acc=AA.
- Sleep: LDI 11; SLP; LDI 22; HLT.
  - wakeup pulsed during the SLP fetch, then low for 20 cycles → sleeping=1, acc=11.
  - 1-cycle wakeup → acc=22, halted=1.
  - Reset asserted during SLEEP → all outputs return to reset values.
- pc wrap and MUL:
  - 16 NOPs → pc returns to 0 and the program repeats.
  - With `ACC_CPU_MUL_EN`: LDI 10; ST 0; MUL 0 → acc=00, cf=1, zf=1.
  - Without `ACC_CPU_MUL_EN`: the same program leaves acc=10, cf=0.
